// File: rtl/tl_ul_arbiter_pkg.sv
// Shared TL-UL widths, opcode constants and arbiter state encoding.
package tl_ul_arbiter_pkg;

  localparam int TL_ADDR_BITS   = 32;
  localparam int TL_SOURCE_BITS = 8;
  localparam int TL_DATA_BYTES  = 4;
  localparam int TL_DATA_BITS   = TL_DATA_BYTES * 8;

  // A-channel opcodes
  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_GET         = 3'd4;

  // D-channel opcodes
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/tl_ul_arbiter_if.sv
// One TL-UL link (A and D channels) with master/slave views.
interface tl_ul_arbiter_if import tl_ul_arbiter_pkg::*; ();

  logic                      a_valid;
  logic                      a_ready;
  logic [2:0]                a_opcode;
  logic [TL_SOURCE_BITS-1:0] a_source;
  logic [TL_ADDR_BITS-1:0]   a_address;
  logic [TL_DATA_BYTES-1:0]  a_mask;
  logic [TL_DATA_BITS-1:0]   a_data;

  logic                      d_valid;
  logic                      d_ready;
  logic [2:0]                d_opcode;
  logic [TL_SOURCE_BITS-1:0] d_source;
  logic [TL_DATA_BITS-1:0]   d_data;

  modport master (
    output a_valid, a_opcode, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_source, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_source, d_data
  );

endinterface

// File: rtl/tl_rr_pick2.sv
// Two-way round-robin pick: on contention the master not granted last wins.
module tl_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  // Single requester wins outright; two requesters alternate against last.
  always_comb begin
    any    = |req;
    winner = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/tl_ul_arbiter.sv
// Shares one TL-UL slave between two masters, one transaction outstanding,
// with a D-channel timeout that aborts a stuck transaction.
module tl_ul_arbiter import tl_ul_arbiter_pkg::*; #(
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  tl_ul_arbiter_if.slave  m0,
  tl_ul_arbiter_if.slave  m1,
  tl_ul_arbiter_if.master s,
  output logic            grant,
  output logic            busy,
  output logic            timeout_err
);

  localparam logic [15:0] COUNT_LAST = 16'(TIMEOUT - 1);

  arb_state_e  state_reg, state_next;
  logic        grant_reg, grant_next;
  logic        last_grant_reg, last_grant_next;
  logic [15:0] count_reg, count_next;
  logic        timeout_err_reg, timeout_err_next;

  logic        pick_winner;
  logic        pick_any;
  logic        in_issue;
  logic        in_wait_d;
  logic        sel_a_valid;
  logic        sel_d_ready;
  logic        a_hs;
  logic        d_hs;

  tl_rr_pick2 u_pick (
    .req    ({m1.a_valid, m0.a_valid}),
    .last   (last_grant_reg),
    .winner (pick_winner),
    .any    (pick_any)
  );

  assign in_issue    = (state_reg == ST_ISSUE);
  assign in_wait_d   = (state_reg == ST_WAIT_D);
  assign sel_a_valid = grant_reg ? m1.a_valid : m0.a_valid;
  assign sel_d_ready = grant_reg ? m1.d_ready : m0.d_ready;
  assign a_hs        = in_issue && sel_a_valid && s.a_ready;
  assign d_hs        = in_wait_d && s.d_valid && sel_d_ready;

  // State register and bookkeeping; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      grant_reg       <= 1'b0;
      last_grant_reg  <= 1'b1;
      count_reg       <= 16'd0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      last_grant_reg  <= last_grant_next;
      count_reg       <= count_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  // Next-state logic; a D handshake wins over a timeout in the same cycle.
  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    last_grant_next  = last_grant_reg;
    count_next       = count_reg;
    timeout_err_next = timeout_err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick_any) begin
          grant_next = pick_winner;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (a_hs) begin
          state_next = ST_WAIT_D;
          count_next = 16'd0;
        end
      end
      ST_WAIT_D: begin
        if (d_hs) begin
          state_next      = ST_IDLE;
          last_grant_next = grant_reg;
        end else if (count_reg == COUNT_LAST) begin
          state_next       = ST_IDLE;
          last_grant_next  = grant_reg;
          timeout_err_next = 1'b1;
        end else if (count_reg != 16'hFFFF) begin
          count_next = count_reg + 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A channel: granted master mirrored to the slave only while issuing.
  assign s.a_valid   = in_issue && sel_a_valid;
  assign s.a_opcode  = grant_reg ? m1.a_opcode  : m0.a_opcode;
  assign s.a_source  = grant_reg ? m1.a_source  : m0.a_source;
  assign s.a_address = grant_reg ? m1.a_address : m0.a_address;
  assign s.a_mask    = grant_reg ? m1.a_mask    : m0.a_mask;
  assign s.a_data    = grant_reg ? m1.a_data    : m0.a_data;
  assign m0.a_ready  = in_issue && !grant_reg && s.a_ready;
  assign m1.a_ready  = in_issue &&  grant_reg && s.a_ready;

  // D channel: routed by grant only, and only while waiting for a response.
  assign s.d_ready   = in_wait_d && sel_d_ready;
  assign m0.d_valid  = in_wait_d && !grant_reg && s.d_valid;
  assign m1.d_valid  = in_wait_d &&  grant_reg && s.d_valid;
  assign m0.d_opcode = s.d_opcode;
  assign m0.d_source = s.d_source;
  assign m0.d_data   = s.d_data;
  assign m1.d_opcode = s.d_opcode;
  assign m1.d_source = s.d_source;
  assign m1.d_data   = s.d_data;

  assign grant       = grant_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_tl_ul_arbiter.sv
// Randomized transaction bench for tl_ul_arbiter against a transaction-level model.
module tb_tl_ul_arbiter;
  import tl_ul_arbiter_pkg::*;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic grant, busy, timeout_err;

  tl_ul_arbiter_if m0_if ();
  tl_ul_arbiter_if m1_if ();
  tl_ul_arbiter_if s_if ();

  tl_ul_arbiter #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .m0          (m0_if),
    .m1          (m1_if),
    .s           (s_if),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Transaction-level model state
  logic model_last;
  logic model_err;

  logic [2:0]  pl_op   [2];
  logic [7:0]  pl_src  [2];
  logic [31:0] pl_addr [2];
  logic [3:0]  pl_mask [2];
  logic [31:0] pl_data [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic a_rdy(input logic n);
    return n ? m1_if.a_ready : m0_if.a_ready;
  endfunction

  function automatic logic d_vld(input logic n);
    return n ? m1_if.d_valid : m0_if.d_valid;
  endfunction

  function automatic logic [31:0] d_dat(input logic n);
    return n ? m1_if.d_data : m0_if.d_data;
  endfunction

  function automatic logic [7:0] d_src(input logic n);
    return n ? m1_if.d_source : m0_if.d_source;
  endfunction

  function automatic logic [2:0] d_opc(input logic n);
    return n ? m1_if.d_opcode : m0_if.d_opcode;
  endfunction

  task automatic randomize_payload(input int n);
    int k;
    k = $urandom_range(0, 2);
    pl_op[n]   = (k == 0) ? TL_GET : ((k == 1) ? TL_PUT_FULL : TL_PUT_PARTIAL);
    pl_src[n]  = 8'($urandom);
    pl_addr[n] = $urandom;
    pl_mask[n] = 4'($urandom);
    pl_data[n] = $urandom;
  endtask

  task automatic drive_masters(input logic [1:0] req);
    m0_if.a_valid = req[0]; m0_if.a_opcode = pl_op[0]; m0_if.a_source = pl_src[0];
    m0_if.a_address = pl_addr[0]; m0_if.a_mask = pl_mask[0]; m0_if.a_data = pl_data[0];
    m1_if.a_valid = req[1]; m1_if.a_opcode = pl_op[1]; m1_if.a_source = pl_src[1];
    m1_if.a_address = pl_addr[1]; m1_if.a_mask = pl_mask[1]; m1_if.a_data = pl_data[1];
  endtask

  // One complete transaction; starts and ends 1 time unit after a rising edge.
  task automatic run_txn(input int idx, input logic [1:0] req, input int a_delay,
                         input int d_delay, input logic [31:0] rdata);
    logic w;
    logic [2:0] rop;
    w = (req == 2'b11) ? ~model_last : req[1];
    drive_masters(req);
    @(posedge clk); #1;
    check_val("grant", 32'(grant), 32'(w));
    check_val("busy_issue", 32'(busy), 32'd1);
    for (int k = 0; k < a_delay; k++) begin
      check_val("stall_s_a_valid", 32'(s_if.a_valid), 32'd1);
      check_val("stall_addr", s_if.a_address, pl_addr[w]);
      check_val("stall_win_ready", 32'(a_rdy(w)), 32'd0);
      check_val("stall_lose_ready", 32'(a_rdy(~w)), 32'd0);
      @(posedge clk); #1;
    end
    s_if.a_ready = 1'b1;
    #1;
    check_val("s_a_valid", 32'(s_if.a_valid), 32'd1);
    check_val("win_a_ready", 32'(a_rdy(w)), 32'd1);
    check_val("lose_a_ready", 32'(a_rdy(~w)), 32'd0);
    check_val("a_opcode", 32'(s_if.a_opcode), 32'(pl_op[w]));
    check_val("a_source", 32'(s_if.a_source), 32'(pl_src[w]));
    check_val("a_address", s_if.a_address, pl_addr[w]);
    check_val("a_mask", 32'(s_if.a_mask), 32'(pl_mask[w]));
    check_val("a_data", s_if.a_data, pl_data[w]);
    @(posedge clk); #1;
    drive_masters(2'b00);
    s_if.a_ready = 1'b0;
    if (d_delay >= TMO) begin
      for (int e = 0; e < TMO; e++) begin
        check_val("wait_busy", 32'(busy), 32'd1);
        check_val("wait_err", 32'(timeout_err), 32'(model_err));
        @(posedge clk); #1;
      end
      model_err = 1'b1;
      check_val("tmo_err", 32'(timeout_err), 32'd1);
      check_val("tmo_idle", 32'(busy), 32'd0);
    end else begin
      repeat (d_delay) begin
        check_val("wait_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
      end
      rop = (pl_op[w] == TL_GET) ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
      s_if.d_valid = 1'b1; s_if.d_opcode = rop; s_if.d_source = pl_src[w]; s_if.d_data = rdata;
      #1;
      check_val("win_d_valid", 32'(d_vld(w)), 32'd1);
      check_val("lose_d_valid", 32'(d_vld(~w)), 32'd0);
      check_val("d_opcode", 32'(d_opc(w)), 32'(rop));
      check_val("d_source", 32'(d_src(w)), 32'(pl_src[w]));
      check_val("d_data", d_dat(w), rdata);
      check_val("s_d_ready", 32'(s_if.d_ready), 32'd1);
      @(posedge clk); #1;
      s_if.d_valid = 1'b0;
      check_val("done_idle", 32'(busy), 32'd0);
      check_val("done_err", 32'(timeout_err), 32'(model_err));
    end
    model_last = w;
    $display("txn %0d: req=%b winner=%0d a_delay=%0d d_delay=%0d timeout=%0d",
             idx, req, w, a_delay, d_delay, (d_delay >= TMO));
  endtask

  // Idle cycle with a stray slave response that must not leak to any master.
  task automatic stray_d;
    s_if.d_valid = 1'b1; s_if.d_data = $urandom;
    #1;
    check_val("stray_m0_d_valid", 32'(m0_if.d_valid), 32'd0);
    check_val("stray_m1_d_valid", 32'(m1_if.d_valid), 32'd0);
    check_val("stray_s_d_ready", 32'(s_if.d_ready), 32'd0);
    @(posedge clk); #1;
    s_if.d_valid = 1'b0;
    check_val("stray_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [1:0] r;
    model_last = 1'b1;
    model_err  = 1'b0;
    for (int n = 0; n < 2; n++) randomize_payload(n);
    drive_masters(2'b00);
    m0_if.d_ready = 1'b1; m1_if.d_ready = 1'b1;
    s_if.a_ready = 1'b0; s_if.d_valid = 1'b0;
    s_if.d_opcode = 3'd0; s_if.d_source = 8'd0; s_if.d_data = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_err", 32'(timeout_err), 32'd0);
    check_val("rst_s_a_valid", 32'(s_if.a_valid), 32'd0);
    check_val("rst_s_d_ready", 32'(s_if.d_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Contention: both masters request, four rounds
    for (int i = 0; i < 4; i++) begin
      for (int n = 0; n < 2; n++) randomize_payload(n);
      run_txn(i, 2'b11, 0, 1, $urandom);
    end

    // Single Get from m0
    pl_op[0] = TL_GET; pl_src[0] = 8'd3; pl_addr[0] = 32'h100;
    run_txn(4, 2'b01, 0, 2, 32'hDEADBEEF);

    // Backpressure on the A channel
    randomize_payload(0);
    run_txn(5, 2'b01, 5, 0, $urandom);

    // Response arriving in the last cycle before timeout
    randomize_payload(1);
    run_txn(6, 2'b10, 1, TMO - 1, $urandom);

    stray_d();

    // Slave never answers
    randomize_payload(0);
    run_txn(7, 2'b01, 0, TMO, $urandom);

    // Next request served after the timeout
    randomize_payload(1);
    run_txn(8, 2'b10, 0, 3, $urandom);

    // Randomized traffic
    for (int i = 9; i < 49; i++) begin
      r = 2'($urandom_range(1, 3));
      for (int n = 0; n < 2; n++) randomize_payload(n);
      run_txn(i, r, $urandom_range(0, 3), $urandom_range(0, TMO + 1), $urandom);
      if ($urandom_range(0, 3) == 0) stray_d();
    end

    // Reset while waiting on D
    randomize_payload(1);
    drive_masters(2'b10);
    @(posedge clk); #1;
    s_if.a_ready = 1'b1;
    @(posedge clk); #1;
    drive_masters(2'b00);
    s_if.a_ready = 1'b0;
    check_val("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_last = 1'b1;
    model_err  = 1'b0;
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_grant", 32'(grant), 32'd0);
    check_val("mid_rst_err", 32'(timeout_err), 32'd0);
    stray_d();
    $display("txn 49: reset during WAIT_D");

    // After reset, contention goes to master 0 first
    for (int n = 0; n < 2; n++) randomize_payload(n);
    run_txn(50, 2'b11, 0, 1, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
